pipeline_dump_sequencer: RTL and testbench

Run/step controller and state-dump scheduler for the five-stage MIPS pipeline. Gates the PC through `stop_pc` (free-run or single-cycle step). After each halt it walks every debug read source in a fixed order: PC, stage latches via the latch mux, register file, then data memory. Each 32-bit word is serialized as four bytes onto the UART transmitter's byte handshake. It sits between the command decoder (UART RX side) and the pipeline's debug taps.

---
 rtl/pipeline_dump_sequencer_pkg.sv | 38 +++
 rtl/word_serializer.sv | 47 ++++
 rtl/pipeline_dump_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pipeline_dump_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_dump_sequencer_pkg.sv
// Shared types, sizes and helpers for the pipeline run/step and state-dump sequencer.
package pipeline_dump_sequencer_pkg;

    localparam int unsigned DEF_LATCH_WORDS = 21;
    localparam int unsigned DEF_REG_WORDS   = 32;
    localparam int unsigned DEF_MEM_WORDS   = 32;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned LATCH_SEL_W = 7;
    localparam int unsigned INDEX_W     = 7;
    localparam int unsigned STATE_W     = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 3'd1;
    localparam logic [STATE_W-1:0] ST_STEP = 3'd2;
    localparam logic [STATE_W-1:0] ST_ADDR = 3'd3;
    localparam logic [STATE_W-1:0] ST_WAIT = 3'd4;
    localparam logic [STATE_W-1:0] ST_SEND = 3'd5;
    localparam logic [STATE_W-1:0] ST_ACK  = 3'd6;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd7;

    // Dump phases, walked in declaration order.
    typedef enum logic [1:0] {
        PH_PC    = 2'd0,
        PH_LATCH = 2'd1,
        PH_REG   = 2'd2,
        PH_MEM   = 2'd3
    } phase_t;

    // Total bytes sent by one complete dump (PC word plus all source words, 4 bytes each).
    function automatic int unsigned dumpBytes(input int unsigned latchWords,
                                              input int unsigned regWords,
                                              input int unsigned memWords);
        return 4 * (1 + latchWords + regWords + memWords);
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Serializes one 32-bit word as four MSB-first bytes over the UART byte handshake.
module word_serializer
    import pipeline_dump_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] loadWord,
    input  logic              send,
    input  logic              ackEn,
    input  logic              txDone,
    output logic              txStart,
    output logic [BYTE_W-1:0] txData,
    output logic              byteDone_c,
    output logic              wordDone_c
);

    logic [WORD_W-1:0] shiftWord;
    logic [1:0]        byteCnt;

    // tx_done only counts while the controller is waiting for an acknowledge.
    assign byteDone_c = ackEn & txDone;
    assign wordDone_c = byteDone_c & (byteCnt == 2'd3);

    // Shift register, byte counter and registered transmit handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shiftWord <= '0;
            byteCnt   <= '0;
            txStart   <= 1'b0;
            txData    <= '0;
        end else begin
            txStart <= send;
            if (send) begin
                txData <= shiftWord[WORD_W-1 -: BYTE_W];
            end
            if (load) begin
                shiftWord <= loadWord;
                byteCnt   <= '0;
            end else if (byteDone_c) begin
                shiftWord <= {shiftWord[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
                byteCnt   <= byteCnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/pipeline_dump_sequencer.sv
// Run/step controller for the five-stage pipeline plus post-halt debug state dump over UART.
module pipeline_dump_sequencer
    import pipeline_dump_sequencer_pkg::*;
#(
    parameter int unsigned LATCH_WORDS = DEF_LATCH_WORDS,
    parameter int unsigned REG_WORDS   = DEF_REG_WORDS,
    parameter int unsigned MEM_WORDS   = DEF_MEM_WORDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_run,
    input  logic                   cmd_step,
    input  logic                   halt_req,
    input  logic [WORD_W-1:0]      pc_in,
    input  logic [WORD_W-1:0]      latch_data,
    input  logic [WORD_W-1:0]      fr_data,
    input  logic [WORD_W-1:0]      mem_data,
    input  logic                   tx_done,
    output logic                   stop_pc,
    output logic                   debug_on,
    output logic [LATCH_SEL_W-1:0] latch_sel,
    output logic [WORD_W-1:0]      debug_addr,
    output logic                   tx_start,
    output logic [BYTE_W-1:0]      tx_data,
    output logic                   busy,
    output logic                   dump_done
);

    localparam logic [INDEX_W-1:0] LATCH_LAST = INDEX_W'(LATCH_WORDS - 1);
    localparam logic [INDEX_W-1:0] REG_LAST   = INDEX_W'(REG_WORDS - 1);
    localparam logic [INDEX_W-1:0] MEM_LAST   = INDEX_W'(MEM_WORDS - 1);

    logic [STATE_W-1:0]     state, stateNext;
    phase_t                 phase, phaseNext;
    logic [INDEX_W-1:0]     index, indexNext;
    logic [LATCH_SEL_W-1:0] latchSelNext;
    logic [WORD_W-1:0]      debugAddrNext;
    logic                   stopPcNext, debugOnNext, busyNext, dumpDoneNext;
    logic                   serLoad, serSend, ackEn;
    logic [WORD_W-1:0]      captureWord;
    logic                   byteDone, wordDone;

    // True when idx is the final word of the given phase.
    function automatic logic isLastIndex(input phase_t ph, input logic [INDEX_W-1:0] idx);
        case (ph)
            PH_PC:    return idx == '0;
            PH_LATCH: return idx == LATCH_LAST;
            PH_REG:   return idx == REG_LAST;
            PH_MEM:   return idx == MEM_LAST;
            default:  return 1'b1;
        endcase
    endfunction

    assign ackEn = (state == ST_ACK);

    // Next-state, dump cursor and next registered output values.
    always_comb begin
        stateNext     = state;
        phaseNext     = phase;
        indexNext     = index;
        latchSelNext  = latch_sel;
        debugAddrNext = debug_addr;
        serLoad       = 1'b0;
        serSend       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cmd_step) begin
                    stateNext = ST_STEP;
                end else if (cmd_run) begin
                    stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    stateNext = ST_ADDR;
                    phaseNext = PH_PC;
                    indexNext = '0;
                end
            end
            ST_STEP: begin
                stateNext = ST_ADDR;
                phaseNext = PH_PC;
                indexNext = '0;
            end
            ST_ADDR: stateNext = ST_WAIT;
            ST_WAIT: begin
                serLoad   = 1'b1;
                stateNext = ST_SEND;
            end
            ST_SEND: begin
                serSend   = 1'b1;
                stateNext = ST_ACK;
            end
            ST_ACK: begin
                if (wordDone) begin
                    if (!isLastIndex(phase, index)) begin
                        indexNext = index + INDEX_W'(1);
                        stateNext = ST_ADDR;
                    end else if (phase == PH_MEM) begin
                        stateNext = ST_DONE;
                    end else begin
                        phaseNext = phase_t'(phase + 2'd1);
                        indexNext = '0;
                        stateNext = ST_ADDR;
                    end
                end else if (byteDone) begin
                    stateNext = ST_SEND;
                end
            end
            ST_DONE: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase

        // Source address is valid for the whole ADDR cycle so the registered read lands in WAIT.
        if (stateNext == ST_ADDR) begin
            case (phaseNext)
                PH_LATCH:       latchSelNext  = LATCH_SEL_W'(indexNext);
                PH_REG, PH_MEM: debugAddrNext = WORD_W'(indexNext);
                default: ;
            endcase
        end

        stopPcNext   = !((stateNext == ST_RUN) || (stateNext == ST_STEP));
        debugOnNext  = stateNext inside {ST_ADDR, ST_WAIT, ST_SEND, ST_ACK};
        busyNext     = (stateNext != ST_IDLE);
        dumpDoneNext = (stateNext == ST_DONE);
    end

    // Capture mux for the word being dumped.
    always_comb begin
        case (phase)
            PH_PC:    captureWord = pc_in;
            PH_LATCH: captureWord = latch_data;
            PH_REG:   captureWord = fr_data;
            PH_MEM:   captureWord = mem_data;
            default:  captureWord = pc_in;
        endcase
    end

    // State, dump cursor and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            phase      <= PH_PC;
            index      <= '0;
            stop_pc    <= 1'b1;
            debug_on   <= 1'b0;
            latch_sel  <= '0;
            debug_addr <= '0;
            busy       <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            state      <= stateNext;
            phase      <= phaseNext;
            index      <= indexNext;
            stop_pc    <= stopPcNext;
            debug_on   <= debugOnNext;
            latch_sel  <= latchSelNext;
            debug_addr <= debugAddrNext;
            busy       <= busyNext;
            dump_done  <= dumpDoneNext;
        end
    end

    word_serializer uSerializer (
        .clk        (clk),
        .rst        (rst),
        .load       (serLoad),
        .loadWord   (captureWord),
        .send       (serSend),
        .ackEn      (ackEn),
        .txDone     (tx_done),
        .txStart    (tx_start),
        .txData     (tx_data),
        .byteDone_c (byteDone),
        .wordDone_c (wordDone)
    );

endmodule

// File: tb/tb_pipeline_dump_sequencer.sv
// Directed bench for pipeline_dump_sequencer: step, run, command noise, slow UART and reset abort.
module tb_pipeline_dump_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_run, cmd_step, halt_req, tx_done;
    logic [31:0] pc_in, latch_data, fr_data, mem_data;
    logic        stop_pc, debug_on, tx_start, busy, dump_done;
    logic [6:0]  latch_sel;
    logic [31:0] debug_addr;
    logic [7:0]  tx_data;

    int checks = 0;
    int errors = 0;

    int stopLowCnt = 0;
    int txStartCnt = 0;

    logic [7:0]  txBytes[$];
    logic [6:0]  selQ[$];
    logic [31:0] addrQ[$];
    bit          onOk;
    bit          holdOk;

    pipeline_dump_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_run    (cmd_run),
        .cmd_step   (cmd_step),
        .halt_req   (halt_req),
        .pc_in      (pc_in),
        .latch_data (latch_data),
        .fr_data    (fr_data),
        .mem_data   (mem_data),
        .tx_done    (tx_done),
        .stop_pc    (stop_pc),
        .debug_on   (debug_on),
        .latch_sel  (latch_sel),
        .debug_addr (debug_addr),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .busy       (busy),
        .dump_done  (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pipeline model: PC advances by 4 on every clock where stop_pc is low.
    always @(posedge clk or posedge rst) begin
        if (rst) pc_in <= 32'h0000_0010;
        else if (!stop_pc) pc_in <= pc_in + 32'd4;
    end

    // Registered debug read ports.
    always @(posedge clk) begin
        latch_data <= 32'h1100_0000 + {25'b0, latch_sel};
        fr_data    <= 32'hA000_0000 + {27'b0, debug_addr[4:0]};
        mem_data   <= 32'h5000_0000 + debug_addr;
    end

    // Cycle counters for stop_pc low time and tx_start pulses.
    always @(posedge clk) begin
        if (stop_pc === 1'b0) stopLowCnt++;
        if (tx_start === 1'b1) txStartCnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expWord(input int w, input logic [31:0] pcExp);
        if (w == 0)       return pcExp;
        else if (w <= 21) return 32'h1100_0000 + 32'(w - 1);
        else if (w <= 53) return 32'hA000_0000 + 32'(w - 22);
        else              return 32'h5000_0000 + 32'(w - 54);
    endfunction

    // Acts as the UART transmitter: answers each tx_start with tx_done after a delay.
    task automatic serviceDump(input string name, input int firstDelay, input int delay,
                               input int maxBytes, input bit noise, input bit stopInAck,
                               output int firstGap, output int nBytes);
        int t;
        int d;
        logic [7:0] held;
        bit stable;
        txBytes.delete();
        selQ.delete();
        addrQ.delete();
        onOk     = 1'b1;
        holdOk   = 1'b1;
        nBytes   = 0;
        firstGap = -1;
        while (nBytes < maxBytes) begin
            t = 0;
            while (tx_start !== 1'b1 && t < 64) begin
                if (noise) begin
                    tx_done  = 1'b1;
                    cmd_run  = 1'b1;
                    cmd_step = 1'b1;
                    halt_req = 1'b1;
                end
                @(negedge clk);
                t++;
            end
            tx_done  = 1'b0;
            cmd_run  = 1'b0;
            cmd_step = 1'b0;
            halt_req = 1'b0;
            if (tx_start !== 1'b1) begin
                check($sformatf("%s_tx_start_wait_byte%0d", name, nBytes), 32'(tx_start), 32'd1);
                return;
            end
            if (nBytes == 0) firstGap = t;
            else check($sformatf("%s_gap_byte%0d", name, nBytes), 32'(t),
                       (nBytes % 4 == 0) ? 32'd3 : 32'd1);
            txBytes.push_back(tx_data);
            if (nBytes % 4 == 0) begin
                selQ.push_back(latch_sel);
                addrQ.push_back(debug_addr);
            end
            if (debug_on !== 1'b1 || busy !== 1'b1) onOk = 1'b0;
            nBytes++;
            if (stopInAck && nBytes == maxBytes) return;
            d      = (nBytes == 1) ? firstDelay : delay;
            held   = tx_data;
            stable = 1'b1;
            for (int i = 0; i < d; i++) begin
                @(negedge clk);
                if (tx_start !== 1'b0 || tx_data !== held) stable = 1'b0;
            end
            if (!stable) holdOk = 1'b0;
            if (d > 100) check($sformatf("%s_long_wait_hold", name), 32'(stable), 32'd1);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    endtask

    // Reassembles the captured bytes MSB-first and compares against the source models.
    task automatic checkDump(input string name, input logic [31:0] pcExp);
        logic [31:0] word;
        check({name, "_byte_count"}, 32'(txBytes.size()), 32'd344);
        check({name, "_debug_on_busy_at_tx"}, 32'(onOk), 32'd1);
        check({name, "_tx_pulse_and_hold"}, 32'(holdOk), 32'd1);
        for (int w = 0; w < 86; w++) begin
            if (4 * w + 3 < txBytes.size()) begin
                word = {txBytes[4*w], txBytes[4*w+1], txBytes[4*w+2], txBytes[4*w+3]};
                check($sformatf("%s_word%0d", name, w), word, expWord(w, pcExp));
                if (w >= 1 && w <= 21)
                    check($sformatf("%s_latch_sel%0d", name, w), 32'(selQ[w]), 32'(w - 1));
                else if (w >= 22 && w <= 53)
                    check($sformatf("%s_reg_addr%0d", name, w), addrQ[w], 32'(w - 22));
                else if (w >= 54)
                    check($sformatf("%s_mem_addr%0d", name, w), addrQ[w], 32'(w - 54));
            end
        end
    endtask

    int firstGap;
    int nBytes;
    int stopBase;
    int txBase;

    initial begin
        rst      = 1'b1;
        cmd_run  = 1'b0;
        cmd_step = 1'b0;
        halt_req = 1'b0;
        tx_done  = 1'b0;

        // Reset held: all outputs at reset values.
        repeat (3) @(negedge clk);
        check("rst_stop_pc",    32'(stop_pc),   32'd1);
        check("rst_busy",       32'(busy),      32'd0);
        check("rst_tx_start",   32'(tx_start),  32'd0);
        check("rst_debug_on",   32'(debug_on),  32'd0);
        check("rst_dump_done",  32'(dump_done), 32'd0);
        check("rst_latch_sel",  32'(latch_sel), 32'd0);
        check("rst_debug_addr", debug_addr,     32'd0);
        check("rst_tx_data",    32'(tx_data),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // halt_req and tx_done while idle do nothing.
        txBase = txStartCnt;
        for (int i = 0; i < 6; i++) begin
            halt_req = 1'b1;
            tx_done  = (i % 2 == 0);
            @(negedge clk);
        end
        halt_req = 1'b0;
        tx_done  = 1'b0;
        @(negedge clk);
        check("idle_noise_busy",    32'(busy),                32'd0);
        check("idle_noise_stop_pc", 32'(stop_pc),             32'd1);
        check("idle_noise_tx",      32'(txStartCnt - txBase), 32'd0);
        check("idle_pc_frozen",     pc_in,                    32'h0000_0010);

        // Step and run together: single step, first byte acknowledged after 1000 cycles.
        stopBase = stopLowCnt;
        txBase   = txStartCnt;
        cmd_step = 1'b1;
        cmd_run  = 1'b1;
        @(negedge clk);
        cmd_step = 1'b0;
        cmd_run  = 1'b0;
        check("step_busy",    32'(busy),    32'd1);
        check("step_stop_pc", 32'(stop_pc), 32'd0);
        serviceDump("step", 1000, 5, 344, 1'b0, 1'b0, firstGap, nBytes);
        check("step_first_latency", 32'(firstGap), 32'd4);
        check("step_dump_done",     32'(dump_done), 32'd1);
        check("step_done_debug_on", 32'(debug_on),  32'd0);
        check("step_tx_pulses",     32'(txStartCnt - txBase), 32'd344);
        if (txBytes.size() >= 4) begin
            check("step_byte0", 32'(txBytes[0]), 32'h00);
            check("step_byte1", 32'(txBytes[1]), 32'h00);
            check("step_byte2", 32'(txBytes[2]), 32'h00);
            check("step_byte3", 32'(txBytes[3]), 32'h14);
        end
        checkDump("step", 32'h0000_0014);
        @(negedge clk);
        check("step_done_pulse_end", 32'(dump_done), 32'd0);
        check("step_idle_busy",      32'(busy),      32'd0);
        check("step_stop_low_cycles", 32'(stopLowCnt - stopBase), 32'd1);
        check("step_pc_after",       pc_in,          32'h0000_0014);

        // Free run for 100 cycles, with command and tx_done noise during the dump.
        stopBase = stopLowCnt;
        cmd_run  = 1'b1;
        @(negedge clk);
        cmd_run = 1'b0;
        repeat (99) @(negedge clk);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        check("run_stopped", 32'(stop_pc), 32'd1);
        serviceDump("run", 2, 2, 344, 1'b1, 1'b0, firstGap, nBytes);
        check("run_first_latency",   32'(firstGap),  32'd3);
        check("run_dump_done",       32'(dump_done), 32'd1);
        check("run_stop_low_cycles", 32'(stopLowCnt - stopBase), 32'd100);
        checkDump("run", 32'h0000_01A4);
        @(negedge clk);
        check("run_idle_busy", 32'(busy), 32'd0);

        // Reset while waiting for the acknowledge of byte 50 aborts the dump.
        cmd_step = 1'b1;
        @(negedge clk);
        cmd_step = 1'b0;
        serviceDump("abort", 3, 3, 50, 1'b0, 1'b1, firstGap, nBytes);
        check("abort_bytes_sent", 32'(nBytes), 32'd50);
        rst = 1'b1;
        @(negedge clk);
        check("abort_stop_pc",    32'(stop_pc),   32'd1);
        check("abort_busy",       32'(busy),      32'd0);
        check("abort_tx_start",   32'(tx_start),  32'd0);
        check("abort_debug_on",   32'(debug_on),  32'd0);
        check("abort_dump_done",  32'(dump_done), 32'd0);
        check("abort_latch_sel",  32'(latch_sel), 32'd0);
        check("abort_debug_addr", debug_addr,     32'd0);
        check("abort_tx_data",    32'(tx_data),   32'd0);
        rst    = 1'b0;
        txBase = txStartCnt;
        for (int i = 0; i < 30; i++) begin
            tx_done = (i % 3 == 0);
            @(negedge clk);
        end
        tx_done = 1'b0;
        check("abort_no_more_tx", 32'(txStartCnt - txBase), 32'd0);
        check("abort_idle_busy",  32'(busy),                32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
